// File: rtl/seq_divider32_pkg.sv
// Shared definitions for the sequential divider: FSM encodings, default width, per-op flags.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_divider32_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Flags captured at start and consumed in the fix-up cycle.
    typedef struct packed {
        logic sign_q;
        logic sign_r;
        logic dbz;
    } meta_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider32_subtractor33.sv
// Combinational trial subtractor: diff = a - b with borrow out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module seq_divider32_subtractor33 #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow_out
);

    assign {borrow_out, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider32.sv
// Restoring shift-subtract divider for MIPS DIV/DIVU, one quotient bit per clock.
// Latency: done in cycle N+WIDTH+2 after start in cycle N; N+2 for a zero divisor.
// Backpressure: start is ignored while busy; no queueing, accepted again in the done cycle.
module seq_divider32
    import seq_divider32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    meta_t            meta_q;

    logic             a_neg;
    logic             b_neg;
    logic             dvsr_zero;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             accept;

    assign a_neg     = is_signed & dividend[WIDTH-1];
    assign b_neg     = is_signed & divisor[WIDTH-1];
    assign dvsr_zero = (divisor == '0);
    assign a_abs     = a_neg ? (~dividend + ONE) : dividend;
    assign b_abs     = b_neg ? (~divisor + ONE) : divisor;

    assign shifted = {rem_q, quo_q[WIDTH-1]};

    seq_divider32_subtractor33 #(
        .W (WIDTH + 1)
    ) u_trial_sub (
        .a          (shifted),
        .b          ({1'b0, dvsr_q}),
        .diff       (diff),
        .borrow_out (borrow)
    );

    // Shifted remainder is below 2*divisor, so an accepted difference always fits in WIDTH bits.
    assign accept = ~borrow & ~diff[WIDTH];

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            meta_q      <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rem_q         <= '0;
                        count         <= '0;
                        dvsr_q        <= b_abs;
                        // A zero divisor returns the raw dividend, so park it in the quotient register.
                        quo_q         <= dvsr_zero ? dividend : a_abs;
                        meta_q.sign_q <= a_neg ^ b_neg;
                        meta_q.sign_r <= a_neg;
                        meta_q.dbz    <= dvsr_zero;
                        state         <= dvsr_zero ? ST_FIX : ST_RUN;
                    end
                end
                ST_RUN: begin
                    rem_q <= accept ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], accept};
                    count <= count + CNT_ONE;
                    if (count == CNT_LAST) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= meta_q.dbz;
                    state       <= ST_IDLE;
                    if (meta_q.dbz) begin
                        quotient  <= '1;
                        remainder <= quo_q;
                    end else begin
                        quotient  <= meta_q.sign_q ? (~quo_q + ONE) : quo_q;
                        remainder <= meta_q.sign_r ? (~rem_q + ONE) : rem_q;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider32.sv
// Scoreboard bench for seq_divider32: directed corner cases plus randomized DIV/DIVU traffic.
module tb_seq_divider32;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          cyc_start;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   cyc;
    bit   acc;

    seq_divider32 dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // MIPS division semantics from plain arithmetic on wide signed integers.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dbz);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            dbz = 1'b1;
        end else if (s) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            q   = 32'(sa / sb);
            r   = 32'(sa % sb);
            dbz = 1'b0;
        end else begin
            q   = a / b;
            r   = a % b;
            dbz = 1'b0;
        end
    endfunction

    // Caller sits just after a rising edge; start is held for exactly one cycle.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, output bit accepted);
        exp_t e;
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        accepted  = !busy;
        if (accepted) begin
            e.a = a;
            e.b = b;
            ref_div(a, b, s, e.q, e.r, e.dbz);
            e.cyc_start = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy) return;
            @(posedge clk);
            #1;
        end
        n_vec++;
        n_err++;
        $display("FAIL wait_idle: busy actual %b after 100 cycles, required 0", busy);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals completion.
    initial begin
        bit          prev_done;
        exp_t        e;
        logic [31:0] ident;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                check("done_one_cycle", 32'(prev_done), 32'd0);
                check("busy_low_at_done", 32'(busy), 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: actual done=1 at cycle %0d, required no pending op", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    check("latency", 32'(cyc), 32'(e.cyc_start + ((e.b == 32'd0) ? 2 : 34)));
                    if (e.b != 32'd0) begin
                        ident = quotient * e.b + remainder;
                        check("q_times_d_plus_r", ident, e.a);
                    end
                end
            end
            prev_done = done;
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          sel;
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        step(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b0;
        step(1);

        // 100/7 with a start attempt mid-operation that must be dropped.
        issue(32'd100, 32'd7, 1'b0, acc);
        check("accept_idle", 32'(acc), 32'd1);
        step(2);
        issue(32'd9, 32'd3, 1'b0, acc);
        check("ignored_while_busy", 32'(acc), 32'd0);
        wait_idle();
        check("done_cycle_reached", 32'(done), 32'd1);

        // Start in the done cycle is accepted and busy rises the next cycle.
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, acc);
        check("accept_in_done_cycle", 32'(acc), 32'd1);
        check("busy_after_done_start", 32'(busy), 32'd1);
        check("hold_quotient", quotient, 32'd14);
        check("hold_remainder", remainder, 32'd2);
        wait_idle();

        issue(32'hFFFF_FFFF, 32'd1, 1'b0, acc);
        wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc);
        wait_idle();
        issue(32'd5, 32'd0, 1'b0, acc);
        check("busy_dbz", 32'(busy), 32'd1);
        wait_idle();

        // Reset mid-run wipes the op and the held outputs.
        issue(32'd100, 32'd7, 1'b0, acc);
        step(9);
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        exp_q.delete();
        step(1);
        reset = 1'b0;
        issue(32'd50, 32'd8, 1'b0, acc);
        check("accept_after_reset", 32'(acc), 32'd1);
        wait_idle();

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            s   = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            case (sel)
                0: b = 32'd0;
                1: b = ($urandom_range(0, 1) == 1) ? 32'd1 : 32'hFFFF_FFFF;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
                3: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                4: a = a >> $urandom_range(0, 31);
                default: ;
            endcase
            issue(a, b, s, acc);
            check("rand_accept", 32'(acc), 32'd1);
            if (b != 32'd0 && $urandom_range(0, 3) == 0) begin
                step(3);
                issue($urandom, $urandom, 1'($urandom_range(0, 1)), acc);
                check("rand_ignored", 32'(acc), 32'd0);
            end
            wait_idle();
            step($urandom_range(0, 2));
        end

        wait_idle();
        step(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
